// File: rtl/int_ctl_pkg.sv
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared 65C02 core definitions used by the interrupt / halt
//                controller: the halt-state encoding and the default
//                core-reset stretch length.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   // Halt state of the core. The encoding is visible on the state output.
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      STOP = 2'd2
   } halt_state_t;

   // Default number of cycles core_reset is held after reset drops.
   localparam int unsigned c_reset_cycles = 2;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/int_ctl_if.sv
// ============================================================================
//  Interface   : int_ctl_if
//  Description : Pin / sequencer side signals of the interrupt and halt
//                controller.
//                master : pins and sequencer (drives irq_n, nmi_n, sync,
//                         wai, stp; receives irq, nmi, halt, core_reset,
//                         state)
//                slave  : int_ctl
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface int_ctl_if;

   logic       irq_n;       // external IRQ pin, active-low level
   logic       nmi_n;       // external NMI pin, active-low falling edge
   logic       sync;        // core opcode-fetch cycle
   logic       wai;         // one-cycle pulse: WAI executed
   logic       stp;         // one-cycle pulse: STP executed
   logic       irq;         // level IRQ request to the sequencer
   logic       nmi;         // pending NMI request to the sequencer
   logic       halt;        // core clock-enable inhibit
   logic       core_reset;  // stretched core reset
   logic [1:0] state;       // halt state RUN/WAIT/STOP

   modport master (
      output irq_n, nmi_n, sync, wai, stp,
      input  irq, nmi, halt, core_reset, state
   );

   modport slave (
      input  irq_n, nmi_n, sync, wai, stp,
      output irq, nmi, halt, core_reset, state
   );

endinterface : int_ctl_if

`default_nettype wire

// File: rtl/int_ctl_sync2.sv
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous pin.
//                Both flops reset to RESET_VAL so that the output shows the
//                pin's inactive level while reset is asserted.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input
//                o_q  - synchronized output (2 cycles of latency)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_q    <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule : sync2

`default_nettype wire

// File: rtl/int_ctl.sv
// ============================================================================
//  Module      : int_ctl
//  Description : Interrupt and halt controller for the 65C02 core.
//                Conditions the IRQ/NMI pins into sequencer requests,
//                implements the WAI/STP halt states by freezing the core
//                clock enable, and stretches the core reset.
//  Config      : INT_CTL_SYNC_EN - when defined, irq_n/nmi_n pass through
//                2-flop synchronizers (adds 2 cycles of pin latency).
//                Leave undefined only when the pins are synchronous to clk.
//  Parameters  : RESET_CYCLES - core_reset stretch after reset drops (1..15)
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous active-high reset
//                bus   - int_ctl_if.slave (pins, sync/wai/stp in;
//                        irq, nmi, halt, core_reset, state out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_ctl
   import cpu_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = c_reset_cycles
) (
   input  logic        clk,
   input  logic        reset,
   int_ctl_if.slave    bus
);

   logic        w_irq_n_q;
   logic        w_nmi_n_q;
   logic        w_irq_s;
   logic        w_nmi_s;
   logic        w_nmi_edge;

   logic        r_irq;
   logic        r_nmi_prev;
   logic        r_nmi_pend;
   logic        r_halt;
   halt_state_t r_state;
   logic [3:0]  r_cnt;

   // ------------------------------------------------------------------------
   // Pin conditioning
   // ------------------------------------------------------------------------
`ifdef INT_CTL_SYNC_EN
   sync2 #(.RESET_VAL(1'b1)) u_sync_irq (
      .clk (clk),
      .rst (reset),
      .i_d (bus.irq_n),
      .o_q (w_irq_n_q)
   );

   sync2 #(.RESET_VAL(1'b1)) u_sync_nmi (
      .clk (clk),
      .rst (reset),
      .i_d (bus.nmi_n),
      .o_q (w_nmi_n_q)
   );
`else
   assign w_irq_n_q = bus.irq_n;
   assign w_nmi_n_q = bus.nmi_n;
`endif

   assign w_irq_s    = ~w_irq_n_q;
   assign w_nmi_s    = ~w_nmi_n_q;
   assign w_nmi_edge = w_nmi_s & ~r_nmi_prev;

   // ------------------------------------------------------------------------
   // Requests, halt state machine and reset stretch
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq      <= 1'b0;
         // Treat NMI as already active so a pin held low through reset
         // does not produce a request.
         r_nmi_prev <= 1'b1;
         r_nmi_pend <= 1'b0;
         r_state    <= RUN;
         r_halt     <= 1'b0;
         r_cnt      <= 4'(RESET_CYCLES);
      end else begin
         r_irq      <= w_irq_s;
         r_nmi_prev <= w_nmi_s;

         // A new edge has priority over the acknowledge so an NMI arriving
         // while the sequencer takes the previous one is not lost.
         if (w_nmi_edge) begin
            r_nmi_pend <= 1'b1;
         end else if (bus.sync && r_nmi_pend) begin
            r_nmi_pend <= 1'b0;
         end

         case (r_state)
            RUN: begin
               if (bus.stp) begin
                  r_state <= STOP;
                  r_halt  <= 1'b1;
               end else if (bus.wai) begin
                  r_state <= WAIT;
                  r_halt  <= 1'b1;
               end
            end
            WAIT: begin
               // Wake ignores the I flag; the sequencer applies the mask.
               if (r_irq || r_nmi_pend) begin
                  r_state <= RUN;
                  r_halt  <= 1'b0;
               end
            end
            STOP: begin
               // Only reset leaves STOP.
            end
            default: begin
               r_state <= RUN;
               r_halt  <= 1'b0;
            end
         endcase

         if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign bus.irq        = r_irq;
   assign bus.nmi        = r_nmi_pend;
   assign bus.halt       = r_halt;
   assign bus.state      = r_state;
   assign bus.core_reset = reset | (r_cnt != 4'd0);

endmodule : int_ctl

`default_nettype wire

// File: doc/int_ctl.md
# int_ctl

Interrupt and halt controller for the 65C02 core. It conditions the external IRQ/NMI pins into the `irq`/`nmi` request inputs of the microcode controller, and implements the WAI/STP halt states by gating the core's clock enable. It also stretches the core reset. It sits between the chip pins and the core, next to the microcode sequencer.

## Interface
- `RESET_CYCLES`, default 2: number of cycles `core_reset` stays high after `reset` drops (1..15).
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `irq_n` in 1: external IRQ pin, active-low, level-sensitive.
- `nmi_n` in 1: external NMI pin, active-low, falling-edge sensitive.
- `sync` in 1: core is in an opcode-fetch/decode cycle (the sequencer's sync).
- `wai` in 1: one-cycle pulse, core executed WAI.
- `stp` in 1: one-cycle pulse, core executed STP.
- `irq` out 1: level IRQ request to the sequencer. The sequencer applies the I-flag mask, not this block.
- `nmi` out 1: pending NMI request to the sequencer.
- `halt` out 1: core clock-enable inhibit (1 = core frozen).
- `core_reset` out 1: stretched reset to the core.
- `state` out 2: current halt state (RUN/WAIT/STOP).

## Operation
- Pin conditioning: internal levels are `irq_s = ~irq_n` and `nmi_s = ~nmi_n`, after the optional synchronizer (see Configuration).
- `irq` is a registered copy of `irq_s`.
- NMI edge detector:
  - `nmi_prev` is a register holding the last `nmi_s`.
  - An edge is `nmi_s & ~nmi_prev`.
  - An edge sets `nmi_pend`. `nmi` = `nmi_pend`.
- NMI acknowledge: a cycle with `sync & nmi_pend` is the sequencer taking the NMI vector; `nmi_pend` clears at the next edge.
  - Edge and acknowledge in the same cycle: `nmi_pend` stays set. The new edge is not lost.
- A held-low `nmi_n` produces exactly one request. A new request needs a release and a new fall.
- State machine (encoding RUN=0, WAIT=1, STOP=2):
  - RUN → STOP on `stp`.
  - RUN → WAIT on `wai`.
  - `stp` and `wai` together: STOP wins.
  - WAIT → RUN when `irq | nmi_pend` is high. This wake does not depend on the I flag: with I=1 the core simply resumes at the next instruction.
  - STOP leaves only through `reset`.
  - `wai`/`stp` are ignored outside RUN.
- `halt` = (state != RUN), registered together with the state.
- Interrupt pins keep being sampled while halted, so an NMI edge during WAIT or STOP is latched. In STOP it is discarded by the next reset.
- Reset stretch:
  - A 4-bit counter loads `RESET_CYCLES` during `reset`.
  - It decrements to 0 after `reset` drops.
  - `core_reset` = `reset | (cnt != 0)`.

## Timing
- Reset values:
  - `irq`=0, `nmi`=0, `halt`=0, `state`=RUN, `core_reset`=1.
  - `nmi_prev`=1, so a pin already low at reset does not fire. Synchronizer flops reset to the inactive level.
- Reset asserted mid-WAIT, mid-STOP or with an NMI pending: everything returns to the reset values at the next edge.
- Pin latency, for a pin first sampled low at edge N:
  - Without the macro: `irq`/`nmi` are high after edge N.
  - With the macro: high after edge N+2.
- `wai`/`stp` seen high at edge N: `halt`=1 after edge N.
- Wake:
  - Request seen high at edge N: `halt`=0 after edge N.
  - `nmi` is still high when the core resumes, so the first sync takes the NMI.
- `core_reset` falls exactly `RESET_CYCLES` edges after the first edge with `reset`=0.

## Configuration
- `INT_CTL_SYNC_EN` defined:
  - Instantiates 2-flop synchronizers on `irq_n` and `nmi_n`.
  - Adds 2 cycles of pin latency.
  - Required when the pins are asynchronous to `clk`.
- Not defined:
  - Pins are used directly.
  - The pins must be synchronous to `clk`.
  - Latencies as given in Timing.

## Structure
- Shared package `cpu_pkg` holds:
  - The halt-state constants RUN/WAIT/STOP (2-bit).
  - The `RESET_CYCLES` default.
- Sub-module `sync2`: 2-flop synchronizer with a reset-value parameter. It is instantiated twice, only under `INT_CTL_SYNC_EN`.

## Test plan
- Reset with `RESET_CYCLES`=2: `core_reset` falls 2 edges after `reset` drops, and all other outputs are 0.
- `nmi_n` held low through reset and released afterwards: `nmi` never goes high. A later fall sets `nmi`, and a cycle with `sync`=1 clears it.
- NMI edge in the same cycle as `sync & nmi_pend`: `nmi` stays 1. A second `sync` clears it.
- `wai` pulse: `halt`=1 and `state`=WAIT. `irq_n` low for 1 cycle: `halt`=0 on the following edge without the macro, 2 edges later with it.
- `stp` and `wai` in the same cycle: `state`=STOP. IRQ and NMI leave `halt`=1. `reset` returns `state` to RUN and `halt` to 0.
- `irq_n` low for 10 cycles while in RUN: `irq` follows the pin with the configured latency and `halt` stays 0.
